// File: rtl/riscv_pkg.sv
// Core-wide RISC-V constants shared by trace and retire logic.
package riscv_pkg;
  localparam int unsigned XLEN = 32;
endpackage

// File: rtl/trace_pkg.sv
// Commit-trace record format and widths.
// Optional feature: define TRACE_SEQ_EN to add a 32-bit retire sequence index to each record.
package trace_pkg;
  localparam int unsigned DropCntW = 16;
  localparam int unsigned SeqW     = 32;

  typedef struct packed {
    logic [riscv_pkg::XLEN-1:0] pc;
    logic [riscv_pkg::XLEN-1:0] instr;
    logic [4:0]                 reg_addr;
    logic [riscv_pkg::XLEN-1:0] reg_data;
    logic [riscv_pkg::XLEN-1:0] mem_addr;
    logic [riscv_pkg::XLEN-1:0] mem_data;
    logic                       mem_wrt;
`ifdef TRACE_SEQ_EN
    logic [SeqW-1:0]            seq;
`endif
  } trace_rec_t;
endpackage

// File: rtl/trace_compact.sv
// Exclusive prefix sum over retire-valid lanes: each active lane's slot offset
// within the group, plus the group's total record count.
module trace_compact #(
  parameter int unsigned IssueWidth = 2
) (
  input  logic [IssueWidth-1:0]                              update_i,
  output logic [IssueWidth-1:0][$clog2(IssueWidth+1)-1:0]    offset_o,
  output logic [$clog2(IssueWidth+1)-1:0]                    popcount_o
);
  localparam int unsigned OffW = $clog2(IssueWidth + 1);

  logic [OffW-1:0] acc;

  // NOTE: blocking assignments here are intentional -- acc is a running sum
  // that must be read back within the same evaluation of the loop.
  always_comb begin
    acc = '0;
    for (int l = 0; l < IssueWidth; l++) begin
      offset_o[l] = acc;
      acc         = acc + OffW'(update_i[l]);
    end
    popcount_o = acc;
  end
endmodule

// File: rtl/commit_trace_fifo.sv
// Multi-lane commit trace FIFO: retiring lanes are packed in program order into a
// circular buffer and drained one record per handshake. Optional: TRACE_SEQ_EN.
module commit_trace_fifo
  import riscv_pkg::*;
  import trace_pkg::*;
#(
  parameter int unsigned IssueWidth = 2,
  parameter int unsigned Depth      = 16
) (
  input  logic                             clk_i,
  input  logic                             rstn_i,
  input  logic [IssueWidth-1:0]            update_i,
  input  logic [IssueWidth-1:0][XLEN-1:0]  pc_i,
  input  logic [IssueWidth-1:0][XLEN-1:0]  instr_i,
  input  logic [IssueWidth-1:0][XLEN-1:0]  reg_data_i,
  input  logic [IssueWidth-1:0][XLEN-1:0]  mem_addr_i,
  input  logic [IssueWidth-1:0][XLEN-1:0]  mem_data_i,
  input  logic [IssueWidth-1:0][4:0]       reg_addr_i,
  input  logic [IssueWidth-1:0]            mem_wrt_i,
  input  logic                             flush_i,
  output logic                             trc_valid_o,
  input  logic                             trc_ready_i,
  output trace_rec_t                       trc_rec_o,
  output logic [$clog2(Depth):0]           count_o,
  output logic                             overflow_o,
  output logic [DropCntW-1:0]              drop_cnt_o
);
  localparam int unsigned AW   = $clog2(Depth);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned OffW = $clog2(IssueWidth + 1);

  logic [AW-1:0]                  wr_ptr, rd_ptr;
  logic [CW-1:0]                  count;
  logic [IssueWidth-1:0][OffW-1:0] lane_off;
  logic [OffW-1:0]                push_num;
  logic [CW-1:0]                  free_slots;
  logic                           pop, has_push, accept, drop;
  trace_rec_t                     lane_rec [IssueWidth];
  trace_rec_t                     mem      [Depth];

  trace_compact #(.IssueWidth(IssueWidth)) u_compact (
    .update_i   (update_i),
    .offset_o   (lane_off),
    .popcount_o (push_num)
  );

  // A pop in the same cycle frees a slot for the incoming group.
  assign pop        = trc_valid_o && trc_ready_i;
  assign free_slots = CW'(Depth) - count + CW'(pop);
  assign has_push   = |update_i;
  assign accept     = has_push && !flush_i && (CW'(push_num) <= free_slots);
  assign drop       = has_push && !flush_i && !accept;

`ifdef TRACE_SEQ_EN
  logic [SeqW-1:0] seq_cnt;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      seq_cnt <= '0;
    end else if (accept) begin
      seq_cnt <= seq_cnt + SeqW'(push_num);
    end
  end
`endif

  always_comb begin
    for (int l = 0; l < IssueWidth; l++) begin
      lane_rec[l]          = '0;
      lane_rec[l].pc       = pc_i[l];
      lane_rec[l].instr    = instr_i[l];
      lane_rec[l].reg_addr = reg_addr_i[l];
      lane_rec[l].reg_data = (reg_addr_i[l] == 5'd0) ? '0 : reg_data_i[l];
      lane_rec[l].mem_addr = mem_addr_i[l];
      lane_rec[l].mem_data = mem_data_i[l];
      lane_rec[l].mem_wrt  = mem_wrt_i[l];
`ifdef TRACE_SEQ_EN
      lane_rec[l].seq      = seq_cnt + SeqW'(lane_off[l]);
`endif
    end
  end

  // NOTE: the record array has no reset; validity is tracked solely by the
  // pointers and count, so clearing storage would only cost flops.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      for (int l = 0; l < IssueWidth; l++) begin
        if (update_i[l]) begin
          mem[wr_ptr + AW'(lane_off[l])] <= lane_rec[l];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(push_num);
      end
      count <= count - CW'(pop) + (accept ? CW'(push_num) : CW'(0));
    end
  end

  // Drop accounting survives flush; only reset clears it.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else if (drop) begin
      overflow_o <= 1'b1;
      if (drop_cnt_o != '1) begin
        drop_cnt_o <= drop_cnt_o + DropCntW'(1);
      end
    end
  end

  assign trc_valid_o = (count != '0);
  assign trc_rec_o   = mem[rd_ptr];
  assign count_o     = count;
endmodule
